// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: field inputs with valid/ready, and the encoded
// instruction with its address and error flag going out with valid/ready.
interface imm_encoder_if;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [63:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [63:0] o_addr;
  logic        o_err;

  modport master (
    output i_valid, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm, i_ready,
    input  o_ready, o_valid, o_instr, o_addr, o_err
  );

  modport slave (
    input  i_valid, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm, i_ready,
    output o_ready, o_valid, o_instr, o_addr, o_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs opcode, register fields and a decoder-unit immediate into a 32-bit RV instruction word
// through a 2-stage valid/ready pipeline. Optional IMM_ENCODER_DROP_ERR_EN drops error beats.
module imm_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned ADDR_STEP = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  imm_encoder_if.slave bus
`ifdef IMM_ENCODER_DROP_ERR_EN
  ,
  output logic [15:0]  o_err_cnt
`endif
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [2:0] F3Slli   = 3'b001;
  localparam logic [2:0] F3Srai   = 3'b101;

  typedef enum logic [2:0] {FmtR, FmtShift, FmtI, FmtS, FmtSb, FmtU, FmtUj, FmtBad} fmt_e;

  function automatic fmt_e classify(input logic [6:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      OpLoad, OpJalr:  f = FmtI;
      OpImm:           f = (f3 == F3Slli || f3 == F3Srai) ? FmtShift : FmtI;
      OpStore:         f = FmtS;
      OpBranch:        f = FmtSb;
      OpLui, OpAuipc:  f = FmtU;
      OpJal:           f = FmtUj;
      OpReg:           f = FmtR;
      default:         f = FmtBad;
    endcase
    return f;
  endfunction

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q;
  logic        s1_err_q;
  logic [6:0]  s1_opcode_q, s1_funct7_q;
  logic [2:0]  s1_funct3_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [19:0] s1_imm_q;

  // Stage 2 / output state
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] addr_q, addr_d;

  fmt_e in_fmt;
  logic in_err;
  logic sh_ok, s12_ok, s20_ok;
  logic accept, pop, s2_free, s1_fwd, s1_drop;

  always_comb begin
    in_fmt = classify(bus.i_opcode, bus.i_funct3);
    sh_ok  = ~|bus.i_imm[63:5];
    s12_ok = (&bus.i_imm[63:11]) | ~|bus.i_imm[63:11];
    s20_ok = (&bus.i_imm[63:19]) | ~|bus.i_imm[63:19];
    in_err = 1'b1;
    case (in_fmt)
      FmtR:               in_err = 1'b0;
      FmtShift:           in_err = ~sh_ok;
      FmtI, FmtS, FmtSb:  in_err = ~s12_ok;
      FmtU, FmtUj:        in_err = ~s20_ok;
      default:            in_err = 1'b1;
    endcase
  end

`ifdef IMM_ENCODER_DROP_ERR_EN
  assign s1_drop = s1_valid_q & s1_err_q;
`else
  assign s1_drop = 1'b0;
`endif

  assign s2_free     = ~s2_valid_q | bus.i_ready;
  assign bus.o_ready = ~s1_valid_q | s2_free;
  assign accept      = bus.i_valid & bus.o_ready;
  assign pop         = s2_valid_q & bus.i_ready;
  assign s1_fwd      = s1_valid_q & ~s1_drop & s2_free;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_fwd || s1_drop) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s1_fwd) begin
      s2_valid_d = 1'b1;
    end else if (pop) begin
      s2_valid_d = 1'b0;
    end

    addr_d = pop ? addr_q + 64'(ADDR_STEP) : addr_q;

    // Bit scatter inverts what the decode stage gathers for each format.
    instr_d = {25'b0, s1_opcode_q};
    case (s1_fmt_q)
      FmtR:     instr_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtShift: instr_d = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                           s1_opcode_q};
      FmtI:     instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtS:     instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                           s1_opcode_q};
      FmtSb:    instr_d = {s1_imm_q[11], s1_imm_q[9:4], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_imm_q[3:0], s1_imm_q[10], s1_opcode_q};
      FmtU:     instr_d = {s1_imm_q[19:0], s1_rd_q, s1_opcode_q};
      FmtUj:    instr_d = {s1_imm_q[19], s1_imm_q[9:0], s1_imm_q[10], s1_imm_q[18:11], s1_rd_q,
                           s1_opcode_q};
      default:  instr_d = {25'b0, s1_opcode_q};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= 32'h0;
      addr_q     <= BASE_ADDR;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      addr_q     <= addr_d;
      if (s1_fwd) begin
        instr_q <= instr_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_fmt_q    <= in_fmt;
      s1_err_q    <= in_err;
      s1_opcode_q <= bus.i_opcode;
      s1_funct3_q <= bus.i_funct3;
      s1_funct7_q <= bus.i_funct7;
      s1_rd_q     <= bus.i_rd;
      s1_rs1_q    <= bus.i_rs1;
      s1_rs2_q    <= bus.i_rs2;
      s1_imm_q    <= bus.i_imm[19:0];
    end
  end

`ifdef IMM_ENCODER_DROP_ERR_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= 16'h0;
    end else if (s1_drop && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'h1;
    end
  end

  assign o_err_cnt = err_cnt_q;
  assign bus.o_err = 1'b0;
`else
  logic err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (s1_fwd) begin
      err_q <= s1_err_q;
    end
  end

  assign bus.o_err = err_q;
`endif

  assign bus.o_valid = s2_valid_q;
  assign bus.o_instr = instr_q;
  assign bus.o_addr  = addr_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed steps plus randomized beats, checked by decoding each emitted
// word and comparing against range rules evaluated with plain signed arithmetic.
module tb_imm_encoder;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned STEP = 4;
  localparam int FR = 0, FSH = 1, FI = 2, FS = 3, FSB = 4, FU = 5, FUJ = 6, FBAD = 7;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    longint     imm;
  } req_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  imm_encoder_if bus ();
`ifdef IMM_ENCODER_DROP_ERR_EN
  logic [15:0] o_err_cnt;
`endif

  imm_encoder #(
    .BASE_ADDR (BASE),
    .ADDR_STEP (STEP)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
`ifdef IMM_ENCODER_DROP_ERR_EN
    ,
    .o_err_cnt (o_err_cnt)
`endif
  );

  req_t        q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          ndrop = 0;
  logic [63:0] exp_addr;
  logic        stall_prev = 1'b0;
  logic [31:0] held_instr;
  logic [63:0] held_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fmt_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'h03, 7'h67: return FI;
      7'h13:        return (f3 == 3'd1 || f3 == 3'd5) ? FSH : FI;
      7'h23:        return FS;
      7'h63:        return FSB;
      7'h37, 7'h17: return FU;
      7'h6F:        return FUJ;
      7'h33:        return FR;
      default:      return FBAD;
    endcase
  endfunction

  function automatic logic in_range(input req_t r);
    case (fmt_of(r.op, r.f3))
      FR:          return 1'b1;
      FSH:         return r.imm >= 0 && r.imm <= 31;
      FI, FS, FSB: return r.imm >= -2048 && r.imm <= 2047;
      FU, FUJ:     return r.imm >= -524288 && r.imm <= 524287;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic longint sx(input logic [63:0] x, input int n);
    longint t;
    t = longint'(x << (64 - n));
    return t >>> (64 - n);
  endfunction

  function automatic longint want_imm(input req_t r, input int f);
    if (f == FSH) return r.imm & 64'd31;
    if (f == FI || f == FS || f == FSB) return sx(r.imm, 12);
    return sx(r.imm, 20);
  endfunction

  // Decode side: what the immediate-extension stage would hand back for this word.
  function automatic longint got_imm(input logic [31:0] w, input int f);
    case (f)
      FSH:     return longint'({59'b0, w[24:20]});
      FI:      return sx({52'b0, w[31:20]}, 12);
      FS:      return sx({52'b0, w[31:25], w[11:7]}, 12);
      FSB:     return sx({52'b0, w[31], w[7], w[30:25], w[11:8]}, 12);
      FU:      return sx({44'b0, w[31:12]}, 20);
      default: return sx({44'b0, w[31], w[19:12], w[20], w[30:21]}, 20);
    endcase
  endfunction

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input longint imm);
    req_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic req_t cur_req();
    return mk(bus.i_opcode, bus.i_funct3, bus.i_funct7, bus.i_rd, bus.i_rs1, bus.i_rs2,
              longint'(bus.i_imm));
  endfunction

  task automatic set(input req_t r);
    bus.i_opcode = r.op;
    bus.i_funct3 = r.f3;
    bus.i_funct7 = r.f7;
    bus.i_rd     = r.rd;
    bus.i_rs1    = r.rs1;
    bus.i_rs2    = r.rs2;
    bus.i_imm    = r.imm;
    bus.i_valid  = 1'b1;
  endtask

  task automatic check_beat();
    req_t        r;
    int          f;
    logic [31:0] w;
    logic [26:0] gf, ef;
    r = q.pop_front();
    f = fmt_of(r.op, r.f3);
    w = bus.o_instr;
    check("addr", bus.o_addr, exp_addr);
    exp_addr = exp_addr + 64'(STEP);
`ifdef IMM_ENCODER_DROP_ERR_EN
    check("err", bus.o_err, 1'b0);
`else
    check("err", bus.o_err, !in_range(r));
`endif
    if (f == FBAD) begin
      check("unknown_word", w, {25'b0, r.op});
    end else begin
      check("opcode", w[6:0], r.op);
      if (f != FR) check("imm", got_imm(w, f), want_imm(r, f));
      gf = {(f inside {FR, FSH, FI, FU, FUJ}) ? w[11:7] : 5'b0,
            (f inside {FR, FSH, FI, FS, FSB}) ? w[19:15] : 5'b0,
            (f inside {FR, FS, FSB})          ? w[24:20] : 5'b0,
            (f inside {FR, FSH, FI, FS, FSB}) ? w[14:12] : 3'b0,
            (f inside {FR, FSH})              ? w[31:25] : 7'b0};
      ef = {(f inside {FR, FSH, FI, FU, FUJ}) ? r.rd : 5'b0,
            (f inside {FR, FSH, FI, FS, FSB}) ? r.rs1 : 5'b0,
            (f inside {FR, FS, FSB})          ? r.rs2 : 5'b0,
            (f inside {FR, FSH, FI, FS, FSB}) ? r.f3 : 3'b0,
            (f inside {FR, FSH})              ? r.f7 : 7'b0};
      check("fields", gf, ef);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic tick(output logic acc);
    req_t r;
    @(negedge i_clk);
    acc = 1'b0;
    if (!i_rst) begin
      if (stall_prev) begin
        check("hold_valid", bus.o_valid, 1'b1);
        check("hold_instr", bus.o_instr, held_instr);
        check("hold_addr", bus.o_addr, held_addr);
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      held_instr = bus.o_instr;
      held_addr  = bus.o_addr;
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) check("spurious_beat", bus.o_valid, 1'b0);
        else check_beat();
      end
      if (bus.i_valid && bus.o_ready) begin
        acc = 1'b1;
        r = cur_req();
`ifdef IMM_ENCODER_DROP_ERR_EN
        if (!in_range(r)) ndrop++;
        else q.push_back(r);
`else
        q.push_back(r);
`endif
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input req_t r);
    logic acc;
    int   n;
    set(r);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) check("accept_timeout", bus.o_ready, 1'b1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    n = 0;
    while ((q.size() > 0 || bus.o_valid) && n < 100) begin
      tick(acc);
      n++;
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic do_reset();
    logic acc;
    bus.i_valid = 1'b0;
    i_rst = 1'b1;
    tick(acc);
    tick(acc);
    i_rst = 1'b0;
    q.delete();
    exp_addr = BASE;
    stall_prev = 1'b0;
  endtask

  initial begin
    logic   acc, acc2, pending, saw;
    int     sent, cyc, i;
    req_t   r;
    logic [6:0] ops [10];
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    i_rst = 1'b1;
    bus.i_ready = 1'b1;
    set(mk(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 0));
    bus.i_valid = 1'b0;
    do_reset();

    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_instr", bus.o_instr, 32'h0);
    check("rst_addr", bus.o_addr, BASE);
    check("rst_err", bus.o_err, 1'b0);
    check("rst_ready", bus.o_ready, 1'b1);

    // LD x5, -8(x2)
    set(mk(7'h03, 3'd3, 7'h0, 5'd5, 5'd2, 5'd0, -8));
    tick(acc);
    check("ld_accept", acc, 1'b1);
    bus.i_valid = 1'b0;
    check("ld_lat1", bus.o_valid, 1'b0);
    tick(acc);
    check("ld_lat2", bus.o_valid, 1'b1);
    check("ld_instr", bus.o_instr, 32'hFF813283);
    check("ld_addr", bus.o_addr, BASE);
    check("ld_err", bus.o_err, 1'b0);
    drain();

    // SRAI x1, x1, 3 then an out-of-range shift amount
    do_reset();
    set(mk(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 3));
    tick(acc);
    set(mk(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32));
    tick(acc2);
    check("srai_accepts", {acc, acc2}, 2'b11);
    bus.i_valid = 1'b0;
    check("srai0_instr", bus.o_instr, 32'h4030D093);
    check("srai0_err", bus.o_err, 1'b0);
    tick(acc);
`ifndef IMM_ENCODER_DROP_ERR_EN
    check("srai1_valid", bus.o_valid, 1'b1);
    check("srai1_err", bus.o_err, 1'b1);
    check("srai1_addr", bus.o_addr, BASE + 64'd4);
    check("srai1_instr", bus.o_instr, 32'h4000D093);
`endif
    drain();

    // 1000 random in-range branch/jump beats with random valid gaps and backpressure
    do_reset();
    pending = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!pending) begin
        if ($urandom_range(0, 1) == 1)
          r = mk(7'h63, 3'($urandom), 7'h0, 5'($urandom), 5'($urandom), 5'($urandom),
                 longint'($urandom_range(0, 4095)) - 2048);
        else
          r = mk(7'h6F, 3'($urandom), 7'h0, 5'($urandom), 5'($urandom), 5'($urandom),
                 longint'($urandom_range(0, 1048575)) - 524288);
        set(r);
        pending = 1'b1;
      end
      bus.i_valid = ($urandom_range(0, 9) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    check("rand_sent", sent, 1000);
    drain();

    // 300 random beats across all formats, some immediates far out of range
    pending = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < 300 && cyc < 6000) begin
      if (!pending) begin
        r = mk(ops[$urandom_range(0, 9)], 3'($urandom), 7'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), 0);
        case ($urandom_range(0, 2))
          0:       r.imm = longint'($urandom_range(0, 63)) - 16;
          1:       r.imm = longint'($urandom_range(0, 4095)) - 2048;
          default: r.imm = longint'({$urandom, $urandom});
        endcase
        set(r);
        pending = 1'b1;
      end
      bus.i_valid = ($urandom_range(0, 4) != 0);
      bus.i_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    check("mix_sent", sent, 300);
    drain();

    // 8-beat stream with the sink stalled on cycles 3..6
    do_reset();
    i = 0;
    cyc = 0;
    saw = 1'b0;
    while (i < 8 && cyc < 40) begin
      set(mk(7'h03, 3'd3, 7'h0, 5'(i), 5'd1, 5'd0, longint'(i * 8)));
      bus.i_ready = !(cyc >= 3 && cyc <= 6);
      if (!bus.o_ready) saw = 1'b1;
      tick(acc);
      if (acc) i++;
      cyc++;
    end
    check("stall_sent", i, 8);
    check("stall_ready_low", saw, 1'b1);
    drain();
    check("stall_addr_end", bus.o_addr, BASE + 64'd32);

    // Unknown opcode
    do_reset();
    send(mk(7'h7F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 0));
    tick(acc);
`ifdef IMM_ENCODER_DROP_ERR_EN
    check("bad_dropped", bus.o_valid, 1'b0);
    check("bad_cnt", o_err_cnt, 16'd1);
`else
    check("bad_valid", bus.o_valid, 1'b1);
    check("bad_instr", bus.o_instr, 32'h0000007F);
    check("bad_err", bus.o_err, 1'b1);
`endif
    drain();

    // Reset with two beats held in the pipe
    do_reset();
    bus.i_ready = 1'b0;
    set(mk(7'h03, 3'd3, 7'h0, 5'd7, 5'd1, 5'd0, 16));
    tick(acc);
    set(mk(7'h03, 3'd3, 7'h0, 5'd8, 5'd1, 5'd0, 24));
    tick(acc2);
    bus.i_valid = 1'b0;
    check("inflight_accepts", {acc, acc2}, 2'b11);
    check("inflight_valid", bus.o_valid, 1'b1);
    i_rst = 1'b1;
    tick(acc);
    check("midrst_valid", bus.o_valid, 1'b0);
    check("midrst_addr", bus.o_addr, BASE);
    check("midrst_ready", bus.o_ready, 1'b1);
    i_rst = 1'b0;
    q.delete();
    exp_addr = BASE;
    stall_prev = 1'b0;
    bus.i_ready = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      tick(acc);
      if (bus.o_valid) saw = 1'b1;
    end
    check("midrst_quiet", saw, 1'b0);

`ifdef IMM_ENCODER_DROP_ERR_EN
    check("err_cnt_total", o_err_cnt, 64'(ndrop));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
